// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared types and constants for the ADC frame-alignment stage
package adc_pkg;

  typedef enum logic [1:0] {
    ST_SLIP,
    ST_SETTLE,
    ST_CHECK,
    ST_LOCKED
  } align_state_e;

  localparam logic [6:0] DEFAULT_FRAME_PATTERN = 7'b1111000;
  localparam int         OUT_SAMPLE_W          = 16;

endpackage

// File: rtl/adc_sample_pack.sv
// rtl/adc_sample_pack.sv - one channel: extend a SAMPLE_W sample to 16 bits
// ADC_FRAME_ALIGN_SIGN_EXT_EN selects sign extension; otherwise the sample is zero-padded.
module adc_sample_pack
  import adc_pkg::*;
#(
  parameter int SAMPLE_W = 14
) (
  input  logic [SAMPLE_W-1:0]     sample_in,
  output logic [OUT_SAMPLE_W-1:0] sample_out
);

`ifdef ADC_FRAME_ALIGN_SIGN_EXT_EN
  assign sample_out = OUT_SAMPLE_W'($signed(sample_in));
`else
  assign sample_out = OUT_SAMPLE_W'(sample_in);
`endif

endmodule

// File: rtl/adc_frame_align.sv
// rtl/adc_frame_align.sv - LVDS ADC frame lock FSM, bitslip control and sample packing
// ADC_FRAME_ALIGN_SIGN_EXT_EN (in adc_sample_pack) picks sign extension over zero padding.
module adc_frame_align
  import adc_pkg::*;
#(
  parameter int                 NUM_CH        = 2,
  parameter int                 SAMPLE_W      = 14,
  parameter int                 FRAME_W       = 7,
  parameter logic [FRAME_W-1:0] FRAME_PATTERN = FRAME_W'(DEFAULT_FRAME_PATTERN),
  parameter int                 LOCK_COUNT    = 16,
  parameter int                 LOSS_COUNT    = 4,
  parameter int                 SETTLE_CYCLES = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         din_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   din,
  input  logic [FRAME_W-1:0]           frame_in,
  output logic                         bitslip,
  output logic                         locked,
  output logic                         sample_valid,
  output logic [NUM_CH*OUT_SAMPLE_W-1:0] data_out,
  output logic                         slip_wrap,
  output logic [15:0]                  frame_err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(LOSS_COUNT + 1);
  localparam int SLIP_W = (FRAME_W < 2) ? 1 : $clog2(FRAME_W);
  localparam int SET_W  = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  align_state_e state_q, state_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;
  logic              bitslip_q, bitslip_d;
  logic              locked_q, locked_d;
  logic              sample_valid_q, sample_valid_d;
  logic              slip_wrap_q, slip_wrap_d;
  logic [15:0]       frame_err_cnt_q, frame_err_cnt_d;
  logic [NUM_CH*OUT_SAMPLE_W-1:0] data_q, data_d;
  logic [NUM_CH*OUT_SAMPLE_W-1:0] packed_w;
  logic              match;

  assign match = din_valid && (frame_in == FRAME_PATTERN);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adc_sample_pack #(.SAMPLE_W(SAMPLE_W)) u_pack (
      .sample_in  (din[k*SAMPLE_W +: SAMPLE_W]),
      .sample_out (packed_w[k*OUT_SAMPLE_W +: OUT_SAMPLE_W])
    );
  end

  always_comb begin
    state_d         = state_q;
    slip_cnt_d      = slip_cnt_q;
    settle_cnt_d    = settle_cnt_q;
    good_cnt_d      = good_cnt_q;
    bad_cnt_d       = bad_cnt_q;
    bitslip_d       = 1'b0;
    locked_d        = locked_q;
    slip_wrap_d     = slip_wrap_q;
    frame_err_cnt_d = frame_err_cnt_q;
    sample_valid_d  = locked_q && match;
    data_d          = sample_valid_d ? packed_w : data_q;

    case (state_q)
      // SLIP fires regardless of din_valid so the first pulse follows reset immediately.
      ST_SLIP: begin
        bitslip_d    = 1'b1;
        settle_cnt_d = '0;
        good_cnt_d   = '0;
        bad_cnt_d    = '0;
        if (slip_cnt_q == SLIP_W'(FRAME_W - 1)) begin
          slip_cnt_d  = '0;
          slip_wrap_d = 1'b1;
        end else begin
          slip_cnt_d = slip_cnt_q + SLIP_W'(1);
        end
        state_d = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (din_valid) begin
          if (settle_cnt_q + SET_W'(1) == SET_W'(SETTLE_CYCLES)) begin
            settle_cnt_d = '0;
            state_d      = ST_CHECK;
          end else begin
            settle_cnt_d = settle_cnt_q + SET_W'(1);
          end
        end
      end
      ST_CHECK: begin
        if (din_valid) begin
          if (match) begin
            if (good_cnt_q + GOOD_W'(1) == GOOD_W'(LOCK_COUNT)) begin
              good_cnt_d = '0;
              bad_cnt_d  = '0;
              locked_d   = 1'b1;
              state_d    = ST_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + GOOD_W'(1);
            end
          end else begin
            good_cnt_d = '0;
            state_d    = ST_SLIP;
          end
        end
      end
      ST_LOCKED: begin
        if (din_valid) begin
          if (match) begin
            bad_cnt_d = '0;
          end else begin
            if (frame_err_cnt_q != 16'hFFFF) frame_err_cnt_d = frame_err_cnt_q + 16'd1;
            if (bad_cnt_q + BAD_W'(1) == BAD_W'(LOSS_COUNT)) begin
              bad_cnt_d = '0;
              locked_d  = 1'b0;
              state_d   = ST_SLIP;
            end else begin
              bad_cnt_d = bad_cnt_q + BAD_W'(1);
            end
          end
        end
      end
      default: state_d = ST_SLIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_SLIP;
      slip_cnt_q      <= '0;
      settle_cnt_q    <= '0;
      good_cnt_q      <= '0;
      bad_cnt_q       <= '0;
      bitslip_q       <= 1'b0;
      locked_q        <= 1'b0;
      sample_valid_q  <= 1'b0;
      slip_wrap_q     <= 1'b0;
      frame_err_cnt_q <= '0;
      data_q          <= '0;
    end else begin
      state_q         <= state_d;
      slip_cnt_q      <= slip_cnt_d;
      settle_cnt_q    <= settle_cnt_d;
      good_cnt_q      <= good_cnt_d;
      bad_cnt_q       <= bad_cnt_d;
      bitslip_q       <= bitslip_d;
      locked_q        <= locked_d;
      sample_valid_q  <= sample_valid_d;
      slip_wrap_q     <= slip_wrap_d;
      frame_err_cnt_q <= frame_err_cnt_d;
      data_q          <= data_d;
    end
  end

  // Reset must kill an in-flight pulse immediately, not one clock later.
  assign bitslip       = bitslip_q & ~reset;
  assign locked        = locked_q;
  assign sample_valid  = sample_valid_q;
  assign data_out      = data_q;
  assign slip_wrap     = slip_wrap_q;
  assign frame_err_cnt = frame_err_cnt_q;

endmodule

// File: tb/tb_adc_frame_align.sv
// tb/tb_adc_frame_align.sv - self-checking bench for adc_frame_align
module tb_adc_frame_align;

  localparam logic [6:0] PAT = 7'b1111000;
`ifdef ADC_FRAME_ALIGN_SIGN_EXT_EN
  localparam logic [15:0] HI_2001 = 16'hE001;
  localparam logic [15:0] HI_3FFF = 16'hFFFF;
  localparam logic [15:0] HI_2AAA = 16'hEAAA;
`else
  localparam logic [15:0] HI_2001 = 16'h2001;
  localparam logic [15:0] HI_3FFF = 16'h3FFF;
  localparam logic [15:0] HI_2AAA = 16'h2AAA;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [27:0] din;
  logic [6:0]  frame_in;
  logic        bitslip;
  logic        locked;
  logic        sample_valid;
  logic [31:0] data_out;
  logic        slip_wrap;
  logic [15:0] frame_err_cnt;

  adc_frame_align dut (
    .clk           (clk),
    .reset         (reset),
    .din_valid     (din_valid),
    .din           (din),
    .frame_in      (frame_in),
    .bitslip       (bitslip),
    .locked        (locked),
    .sample_valid  (sample_valid),
    .data_out      (data_out),
    .slip_wrap     (slip_wrap),
    .frame_err_cnt (frame_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [6:0]  f;
    logic [27:0] d;
    logic        smp;
    logic [15:0] hi;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n, pulses, last_pulse, min_gap;
  logic [31:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] ext(input logic [27:0] d);
`ifdef ADC_FRAME_ALIGN_SIGN_EXT_EN
    return {{2{d[27]}}, d[27:14], {2{d[13]}}, d[13:0]};
`else
    return {2'b00, d[27:14], 2'b00, d[13:0]};
`endif
  endfunction

  function automatic logic [6:0] rot7(input logic [6:0] p, input int r);
    return (p << r) | (p >> (7 - r));
  endfunction

  task automatic do_reset();
    reset = 1'b1; din_valid = 1'b0; frame_in = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bitslip", bitslip, 0);
    chk("rst_locked", locked, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_slip_wrap", slip_wrap, 0);
    chk("rst_frame_err_cnt", frame_err_cnt, 0);
    sb_q.delete();
    cyc_n = 0; pulses = 0; last_pulse = 0; min_gap = 1000;
    reset = 1'b0;
  endtask

  // One word per clock; expected samples go to the scoreboard as they are driven.
  task automatic cyc(input logic v, input logic [6:0] f, input logic [27:0] d, input logic exp_smp);
    logic [31:0] e;
    din_valid = v; frame_in = f; din = d;
    if (exp_smp) sb_q.push_back(ext(d));
    @(posedge clk);
    #1;
    cyc_n++;
    if (bitslip) begin
      if (pulses > 0 && (cyc_n - last_pulse) < min_gap) min_gap = cyc_n - last_pulse;
      pulses++;
      last_pulse = cyc_n;
    end
    chk("sample_valid", sample_valid, exp_smp);
    if (sample_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        e = sb_q.pop_front();
        chk("data_out", data_out, e);
      end
    end else if (exp_smp && sb_q.size() != 0) begin
      void'(sb_q.pop_back());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int   rot, nmatch;
    logic v;

    // Aligned acquisition: one slip, 3 settle words, 16 matches.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      cyc(1'b1, PAT, 28'($urandom), i >= 21);
      chk("t1_bitslip", bitslip, i == 1);
      chk("t1_locked", locked, i >= 20);
    end
    chk("t1_pulses", pulses, 1);

    // Mismatches while locked: 3 tolerated, then 4 drop lock.
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 7'h00, 28'($urandom), 1'b0);
      chk("t4_locked_hold", locked, 1);
    end
    cyc(1'b1, PAT, 28'($urandom), 1'b1);
    chk("t4_locked_after_match", locked, 1);
    chk("t4_err_cnt3", frame_err_cnt, 3);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 7'h00, 28'($urandom), 1'b0);
      chk("t4_locked_loss", locked, k < 3);
    end
    chk("t4_err_cnt7", frame_err_cnt, 7);
    cyc(1'b1, PAT, 28'($urandom), 1'b0);
    chk("t4_bitslip_after_loss", bitslip, 1);

    // Frame lane rotated by 3; the stub undoes one bit per pulse.
    do_reset();
    rot = 3;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, rot7(PAT, rot), 28'($urandom), i >= 31);
      if (bitslip && rot > 0) rot--;
      chk("t2_locked", locked, i >= 30);
    end
    chk("t2_pulses", pulses, 3);
    chk("t2_min_gap", min_gap, 5);
    chk("t2_slip_wrap", slip_wrap, 0);

    // Frame lane never matches: wrap after the 7th pulse, slipping continues.
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 7'h00, 28'($urandom), 1'b0);
      chk("t3_slip_wrap", slip_wrap, i >= 31);
      chk("t3_locked", locked, 0);
    end
    chk("t3_pulses", pulses, 8);

    // din_valid toggled during CHECK; invalid cycles carry garbage frame words.
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, PAT, 28'($urandom), 1'b0);
    nmatch = 0;
    for (int j = 0; j < 40; j++) begin
      v = 1'(j % 2);
      cyc(v, v ? PAT : 7'h00, 28'($urandom), v && (nmatch >= 16));
      if (v) nmatch++;
      chk("t5_locked", locked, nmatch >= 16);
    end
    chk("t5_pulses", pulses, 1);

    // Table-driven vectors while locked, including extension cases.
    tbl[0] = '{1'b1, PAT,        {14'h2001, 14'h0005}, 1'b1, HI_2001};
    tbl[1] = '{1'b1, PAT,        {14'h1FFF, 14'h3FFF}, 1'b1, 16'h1FFF};
    tbl[2] = '{1'b0, PAT,        {14'h3FFF, 14'h0000}, 1'b0, 16'h0000};
    tbl[3] = '{1'b1, 7'h00,      {14'h0123, 14'h0456}, 1'b0, 16'h0000};
    tbl[4] = '{1'b1, PAT,        {14'h3FFF, 14'h2000}, 1'b1, HI_3FFF};
    tbl[5] = '{1'b1, 7'b1111001, {14'h0111, 14'h0222}, 1'b0, 16'h0000};
    tbl[6] = '{1'b1, PAT,        {14'h0000, 14'h1234}, 1'b1, 16'h0000};
    tbl[7] = '{1'b0, 7'h00,      {14'h3333, 14'h3333}, 1'b0, 16'h0000};
    tbl[8] = '{1'b1, PAT,        {14'h2AAA, 14'h1555}, 1'b1, HI_2AAA};
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].v, tbl[i].f, tbl[i].d, tbl[i].smp);
      if (tbl[i].smp) chk("tbl_hi", data_out[31:16], tbl[i].hi);
    end
    chk("tbl_locked", locked, 1);
    chk("tbl_err_cnt", frame_err_cnt, 2);
    chk("sb_empty", sb_q.size(), 0);

    // Reset arriving during a bitslip pulse.
    do_reset();
    cyc(1'b1, PAT, 28'h0, 1'b0);
    chk("t7_pulse", bitslip, 1);
    reset = 1'b1;
    #1;
    chk("t7_pulse_dropped", bitslip, 0);
    @(posedge clk);
    #1;
    chk("t7_in_reset", bitslip, 0);
    reset = 1'b0;
    cyc(1'b1, PAT, 28'h0, 1'b0);
    chk("t7_repulse", bitslip, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
